// File: rtl/aca_varlat_adder_if.sv
// Operand/result handshake bundle for the variable-latency
// almost-correct adder.
interface aca_varlat_adder_if #(
  parameter int WIDTH = 32
) ();

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH:0]   result_o;
  logic             err_o;

  modport master (
    output valid_i,
    output add1_i,
    output add2_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  result_o,
    input  err_o
  );

  modport slave (
    input  valid_i,
    input  add1_i,
    input  add2_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output result_o,
    output err_o
  );

endinterface

// File: rtl/aca_varlat_adder.sv
// Registered windowed carry-speculation adder with long-chain
// detection, optional one-cycle exact recovery and statistics.
module aca_varlat_adder #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 7,
  parameter int MODE   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  aca_varlat_adder_if.slave bus,
  input  logic             clear_i,
  output logic [CNT_W-1:0] ops_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_FIX,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_res;
  logic             r_err;
  logic             r_valid;
  logic             r_ready;
  logic [CNT_W-1:0] r_ops;
  logic [CNT_W-1:0] r_errs;

  logic [WIDTH-1:0]      w_p;
  logic [WIDTH:0]        w_exact;
  logic [WIDTH:0]        w_spec;
  logic [WIDTH:WINDOW]   w_c;
  logic [WIDTH-WINDOW:0] w_det;
  logic                  w_err;
  logic                  w_hs;

  assign w_p     = r_a ^ r_b;
  assign w_exact = {1'b0, r_a} + {1'b0, r_b};

  // Each upper carry only sees the WINDOW bits just below it.
  for (genvar i = WINDOW; i <= WIDTH; i++) begin : g_carry
    logic [WINDOW:0] w_win;
    assign w_win = {1'b0, r_a[i-1 -: WINDOW]}
                 + {1'b0, r_b[i-1 -: WINDOW]};
    assign w_c[i] = w_win[WINDOW];
  end

  assign w_spec[WINDOW-1:0] = w_exact[WINDOW-1:0];
  for (genvar i = WINDOW; i < WIDTH; i++) begin : g_sum
    assign w_spec[i] = w_p[i] ^ w_c[i];
  end
  assign w_spec[WIDTH] = w_c[WIDTH];

  for (genvar k = 0; k <= WIDTH - WINDOW; k++) begin : g_det
    assign w_det[k] = &w_p[k +: WINDOW];
  end
  assign w_err = |w_det;

  assign w_hs = r_valid & bus.ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.valid_i) begin
            r_a     <= bus.add1_i;
            r_b     <= bus.add2_i;
            r_ready <= 1'b0;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (MODE != 0 && w_err) begin
            r_state <= S_FIX;
          end else begin
            r_res   <= w_spec;
            r_err   <= w_err;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_FIX: begin
          r_res   <= w_exact;
          r_err   <= 1'b1;
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (bus.ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ops  <= '0;
      r_errs <= '0;
    end else if (clear_i) begin
      r_ops  <= '0;
      r_errs <= '0;
    end else if (w_hs) begin
      if (r_ops != '1) r_ops <= r_ops + 1'b1;
      if (r_err && r_errs != '1) r_errs <= r_errs + 1'b1;
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_res;
  assign bus.err_o    = r_err;
  assign ops_cnt_o    = r_ops;
  assign err_cnt_o    = r_errs;

endmodule
